// File: rtl/seg7_scan_if.sv
// seg7_scan_if: display-side bundle for seg7_scan.
// The master end supplies the word to show and the freeze control; the
// slave end (the scanner) returns the active-low anode/segment drive and
// the per-frame strobe.
interface seg7_scan_if;
  logic [15:0] value;   // word to display (counter state)
  logic        freeze;  // hold the current snapshot across frame boundaries
  logic [3:0]  an;      // digit anodes, active-low, an[0] = rightmost digit
  logic [6:0]  seg;     // segments, active-low, {g,f,e,d,c,b,a}
  logic        frame;   // one-cycle pulse after each frame boundary

  modport master (
    output value,
    output freeze,
    input  an,
    input  seg,
    input  frame
  );

  modport slave (
    input  value,
    input  freeze,
    output an,
    output seg,
    output frame
  );
endinterface

// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed 4-digit common-anode hex display driver.
//
// A prescaler (cnt_reg) divides each digit slot into PRESCALE cycles. The
// first DEAD cycles of every slot blank all anodes so the previous digit's
// segment pattern never ghosts onto the next anode. A 2-bit scan FSM steps
// through the four digits. The displayed word is captured into snap_reg
// once per frame (when the last slot of digit 3 ends) so a running counter
// never tears mid-frame; freeze suppresses that capture without touching
// the scan timing.
//
// All outputs are registered from (cnt_reg, state_reg, snap_reg), giving a
// 1-cycle latency and no combinational path from value to the pins.
//
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN
//   When defined, digits 1..3 are blanked while every nibble from that
//   digit upward in the snapshot is zero; digit 0 is always driven, so a
//   zero word shows a single "0".
//
// Parameter constraints: PRESCALE >= 4, 1 <= DEAD < PRESCALE.
module seg7_scan #(
  parameter int PRESCALE = 50000,
  parameter int DEAD     = 8
) (
  input  logic        clk,
  input  logic        reset,
  seg7_scan_if.slave  bus
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD);

  // Digit scan FSM: one state per digit position, right to left.
  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } digit_t;

  digit_t          state_reg;
  digit_t          state_next;
  logic [CW-1:0]   cnt_reg;
  logic [CW-1:0]   cnt_next;
  logic [15:0]     snap_reg;
  logic [15:0]     snap_next;
  logic [3:0]      an_reg;
  logic [3:0]      an_next;
  logic [6:0]      seg_reg;
  logic [6:0]      seg_next;
  logic            frame_reg;

  logic            slot_end;
  logic            frame_end;
  logic            in_dead;
  logic [1:0]      idx;
  logic [3:0]      nib [4];

  // Active-low hex decoder, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign slot_end  = (cnt_reg == CNT_LAST);
  assign frame_end = slot_end && (state_reg == DIG3);
  assign in_dead   = (cnt_reg < CNT_DEAD);
  assign idx       = state_reg;

  // Split the snapshot into per-digit nibbles for the output mux.
  for (genvar gi = 0; gi < 4; gi++) begin : g_nib
    assign nib[gi] = snap_reg[4*gi +: 4];
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // upper_zero[d]: every nibble from digit d upward is zero, so digit d is
  // a leading zero. Digit 0 has no entry because it is never suppressed.
  logic [3:1] upper_zero;
  for (genvar gi = 1; gi < 4; gi++) begin : g_lzb
    assign upper_zero[gi] = (snap_reg[15:4*gi] == '0);
  end
`endif

  // State register for the scan FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= DIG0;
    end else begin
      state_reg <= state_next;
    end
  end

  // Scan FSM next state: advance one digit at the end of every slot.
  always_comb begin
    state_next = state_reg;
    if (slot_end) begin
      case (state_reg)
        DIG0:    state_next = DIG1;
        DIG1:    state_next = DIG2;
        DIG2:    state_next = DIG3;
        default: state_next = DIG0;
      endcase
    end
  end

  // Slot prescaler next value and per-frame snapshot capture.
  always_comb begin
    cnt_next  = slot_end ? '0 : cnt_reg + 1'b1;
    snap_next = snap_reg;
    if (frame_end && !bus.freeze) begin
      snap_next = bus.value;
    end
  end

  // Output decode for the current slot phase; registered below.
  always_comb begin
    an_next  = 4'b1111;
    seg_next = 7'b1111111;
    if (!in_dead) begin
      an_next  = ~(4'b0001 << idx);
      seg_next = hex7(nib[idx]);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (idx != 2'd0 && upper_zero[idx]) begin
        an_next  = 4'b1111;
        seg_next = 7'b1111111;
      end
`endif
    end
  end

  // Prescaler, snapshot and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg   <= '0;
      snap_reg  <= 16'h0000;
      an_reg    <= 4'b1111;
      seg_reg   <= 7'b1111111;
      frame_reg <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      snap_reg  <= snap_next;
      an_reg    <= an_next;
      seg_reg   <= seg_next;
      frame_reg <= frame_end;
    end
  end

  assign bus.an    = an_reg;
  assign bus.seg   = seg_reg;
  assign bus.frame = frame_reg;

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: randomized self-checking bench for seg7_scan
// (PRESCALE=10, DEAD=2). The reference model treats time as a plain cycle
// count since reset: slot = t % P, digit = (t / P) % 4, frame boundary when
// t % (4P) == 4P-1. Outputs are checked every cycle on the falling edge.
// Honours SEG7_LEADING_ZERO_BLANK_EN the same way the design build does.
module tb_seg7_scan;
  localparam int P = 10;
  localparam int D = 2;

  logic clk = 1'b0;
  logic reset;

  seg7_scan_if bus ();

  seg7_scan #(.PRESCALE(P), .DEAD(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Segment patterns, active-low gfedcba, digit 0..F.
  logic [6:0] hex_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int n_checks = 0;
  int n_errors = 0;
  int n_frames = 0;

  // Reference model state.
  int          m_t = 0;
  logic [15:0] m_snap = '0;
  logic        m_valid = 1'b0;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_frame;
  int          m_slot;
  int          m_dig;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t model_t=%0d got=%h want=%h", tag, $time, m_t, obs, exp);
    end
  endtask

  // Reference model: advance one clock using the pre-edge cycle count.
  always @(posedge clk) begin
    if (reset) begin
      m_t       = 0;
      m_snap    = 16'h0000;
      exp_an    = 4'b1111;
      exp_seg   = 7'b1111111;
      exp_frame = 1'b0;
      m_valid   = 1'b1;
    end else begin
      m_slot = m_t % P;
      m_dig  = (m_t / P) % 4;
      if (m_slot < D) begin
        exp_an  = 4'b1111;
        exp_seg = 7'b1111111;
      end else begin
        exp_an  = 4'b1111 & ~(4'(1) << m_dig);
        exp_seg = hex_tab[(m_snap >> (4 * m_dig)) & 16'hF];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (m_dig > 0 && (m_snap >> (4 * m_dig)) == 16'h0) begin
          exp_an  = 4'b1111;
          exp_seg = 7'b1111111;
        end
`endif
      end
      exp_frame = ((m_t % (4 * P)) == (4 * P - 1));
      if (exp_frame && !bus.freeze) m_snap = bus.value;
      m_t++;
    end
  end

  // One cycle: wait for the falling edge and compare all outputs.
  task automatic tick();
    @(negedge clk);
    if (m_valid) begin
      check_eq("an", {12'h0, bus.an}, {12'h0, exp_an});
      check_eq("seg", {9'h0, bus.seg}, {9'h0, exp_seg});
      check_eq("frame", {15'h0, bus.frame}, {15'h0, exp_frame});
      if (exp_frame) begin
        n_frames++;
        $display("frame %0d at t=%0t snapshot=%h freeze=%0b", n_frames, $time, m_snap, bus.freeze);
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    run(n);
    reset = 1'b0;
  endtask

  // Advance until the model sits at the given cycle within the frame.
  task automatic run_to_phase(input int ph);
    for (int i = 0; i < 4 * P && (m_t % (4 * P)) != ph; i++) tick();
  endtask

  initial begin
    reset      = 1'b1;
    bus.value  = 16'h0000;
    bus.freeze = 1'b0;

    // Reset held, then a zero word for one full frame and a bit.
    run(5);
    reset = 1'b0;
    run(45);

    // A fixed word from reset: second frame shows 1234.
    bus.value = 16'h1234;
    do_reset(2);
    run(90);

    // Mid-frame change must not show until the following frame.
    run_to_phase(15);
    bus.value = 16'hABCD;
    run(80);

    // Frozen snapshot while value runs; then released.
    bus.freeze = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      bus.value = bus.value + 16'd1;
    end
    bus.freeze = 1'b0;
    run(50);

    // Reset in the middle of digit 2's slot.
    run_to_phase(25);
    do_reset(1);
    run(45);

    // Leading-zero patterns (fully driven unless blanking is built in).
    bus.value = 16'h0050;
    run(90);
    bus.value = 16'h0000;
    run(90);

    // Randomized traffic: value changes, freeze runs, sparse resets.
    for (int i = 0; i < 4000; i++) begin
      tick();
      if ($urandom_range(0, 19) == 0) begin
        bus.value = 16'($urandom) >> (4 * $urandom_range(0, 4));
      end
      if ($urandom_range(0, 99) < 3) bus.freeze = ~bus.freeze;
      if ($urandom_range(0, 1499) == 0) reset = 1'b1;
      else reset = 1'b0;
    end
    reset = 1'b0;
    run(10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
